uart_tx_param: RTL and testbench

Parametrised UART transmitter: next generation of the fixed 8-bit TX top. Adds configurable data width, an internal baud divider, optional 2 stop bits, a ready/valid input handshake and an optional input FIFO. It sits between the register-file/async-FIFO domain and the UART pin, in the UART clock domain.

---
 rtl/uart_tx_param.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: ready/valid input, internal baud divider, optional parity and 2 stop bits.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-word input FIFO; otherwise a single holding register is used.
module uart_tx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [DIV_WIDTH-1:0]  BAUD_DIV,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tx_q, tx_d;
  logic                  ready_en_q;

  logic                  push;
  logic                  pop;
  logic                  pending;
  logic                  full;
  logic                  start_frame;
  logic                  bit_end;
  logic [DATA_WIDTH-1:0] head;
  logic [DIV_WIDTH-1:0]  live_div;

  // ready_en_q holds READY low during reset and releases it one edge after RST goes high
  assign READY    = ready_en_q && !full;
  assign push     = DATA_VALID && READY;
  assign live_div = (BAUD_DIV == '0) ? DIV_WIDTH'(1) : BAUD_DIV;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= P_DATA;
  end

  assign full    = (count_q == FULL_CNT);
  assign pending = (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (pop) hold_vld_d = 1'b0;
    if (push) begin
      hold_d     = P_DATA;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign full    = hold_vld_q;
  assign pending = hold_vld_q;
  assign head    = hold_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    data_d      = data_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    stop_idx_d  = stop_idx_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    tx_d        = 1'b1;
    bit_end     = (cnt_q == '0);

    // Every non-idle state counts down one bit period and reloads for the following bit
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? (div_q - DIV_WIDTH'(1)) : (cnt_q - DIV_WIDTH'(1));
    end

    case (state_q)
      S_IDLE: begin
        start_frame = pending;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d    = par_en_q ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (pending) begin
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame settings are captured together with the word so later input changes wait for the next frame
    if (start_frame) begin
      pop       = 1'b1;
      state_d   = S_START;
      data_d    = head;
      par_en_d  = PAR_EN;
      par_bit_d = (^head) ^ PAR_TYP;
      stop2_d   = STOP2;
      div_d     = live_div;
      cnt_d     = live_div - DIV_WIDTH'(1);
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[bit_idx_d];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_WIDTH'(1);
      bit_idx_q  <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      ready_en_q <= 1'b1;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = (state_q != S_IDLE) || pending;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: an 8-bit and a 5-bit instance share clock, reset and frame settings;
// the monitor decodes each serial line cycle by cycle against queued hand-written frame strings.
`timescale 1ns/1ps
module tb_uart_tx_param;

  typedef struct {
    string bits;
    int    div;
    bit    b2b;
  } frame_t;

`ifdef UART_TX_FIFO_EN
  localparam int EXP_RUN   = 5;
  localparam int RST_WORDS = 3;
`else
  localparam int EXP_RUN   = 1;
  localparam int RST_WORDS = 2;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  p8;
  logic [4:0]  p5;
  logic        dv8, dv5;
  logic        rdy8, rdy5, tx8, tx5, busy8, busy5;
  logic        par_en, par_typ, stop2;
  logic [15:0] baud_div;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     edge_cnt = 0;
  int     mcyc     = 0;
  bit     mon_off  = 1'b0;
  frame_t exp_q [2][$];
  frame_t cur [2];
  int     pos [2];
  int     last_end [2];
  bit     in_frame [2];
  bit     skip [2];
  logic   bitval [2];
  bit     bitbad [2];
  string  got [2];

  uart_tx_param #(.DATA_WIDTH(8), .DIV_WIDTH(16), .FIFO_DEPTH(4)) dut8 (
    .CLK(CLK), .RST(RST), .P_DATA(p8), .DATA_VALID(dv8), .READY(rdy8),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .BAUD_DIV(baud_div),
    .TX_OUT(tx8), .BUSY(busy8)
  );

  uart_tx_param #(.DATA_WIDTH(5), .DIV_WIDTH(16), .FIFO_DEPTH(4)) dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(p5), .DATA_VALID(dv5), .READY(rdy5),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .BAUD_DIV(baud_div),
    .TX_OUT(tx5), .BUSY(busy5)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  task automatic mon_step(input int l);
    logic t;
    t = (l == 0) ? tx8 : tx5;
    if (mon_off) begin
      in_frame[l] = 1'b0;
      skip[l]     = 1'b0;
      return;
    end
    if (skip[l] && t == 1'b1) skip[l] = 1'b0;
    if (!in_frame[l] && !skip[l] && t == 1'b0) begin
      if (exp_q[l].size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_start lane %0d: got start bit at cycle %0d expected idle line", l, mcyc);
        skip[l] = 1'b1;
      end else begin
        cur[l] = exp_q[l].pop_front();
        if (cur[l].b2b) check($sformatf("gap_lane%0d", l), mcyc - last_end[l], 1);
        in_frame[l] = 1'b1;
        pos[l]      = 0;
        got[l]      = "";
        bitbad[l]   = 1'b0;
      end
    end
    if (in_frame[l]) begin
      if (pos[l] % cur[l].div == 0) bitval[l] = t;
      else if (t !== bitval[l]) bitbad[l] = 1'b1;
      if (pos[l] % cur[l].div == cur[l].div - 1) begin
        got[l]    = {got[l], bitbad[l] ? "x" : (bitval[l] ? "1" : "0")};
        bitbad[l] = 1'b0;
      end
      pos[l]++;
      if (pos[l] == cur[l].bits.len() * cur[l].div) begin
        check_str($sformatf("frame_lane%0d", l), got[l], cur[l].bits);
        in_frame[l] = 1'b0;
        last_end[l] = mcyc;
      end
    end
  endtask

  always @(negedge CLK) begin
    mcyc++;
    mon_step(0);
    mon_step(1);
  end

  task automatic send(input int l, input logic [7:0] w, input string bits, input int div,
                      input bit b2b, output int acc);
    frame_t f;
    bit     r;
    int     n;
    n   = 0;
    acc = -1;
    if (!mon_off) begin
      f.bits = bits;
      f.div  = div;
      f.b2b  = b2b;
      exp_q[l].push_back(f);
    end
    if (l == 0) begin
      p8  = w;
      dv8 = 1'b1;
    end else begin
      p5  = w[4:0];
      dv5 = 1'b1;
    end
    forever begin
      r = (l == 0) ? rdy8 : rdy5;
      @(posedge CLK);
      if (r) begin
        acc = edge_cnt;
        break;
      end
      n++;
      if (n > 2000) begin
        n_checks++;
        $display("FAIL send_timeout lane %0d: READY low for %0d cycles, expected 1", l, n);
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    dv8 = 1'b0;
    dv5 = 1'b0;
  endtask

  task automatic wait_idle(input int l);
    int n;
    n = 0;
    while ((exp_q[l].size() != 0 || in_frame[l]) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      $display("FAIL idle_timeout lane %0d: got %0d frames outstanding expected 0", l, exp_q[l].size());
    end
    @(negedge CLK);
    check($sformatf("busy_end_lane%0d", l), (l == 0) ? busy8 : busy5, 0);
  endtask

  initial begin
    int e [6];
    int run;
    int lows;
    dv8 = 1'b0; dv5 = 1'b0; p8 = '0; p5 = '0;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; baud_div = 16'd4;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_tx", tx8, 1);
    check("rst_busy", busy8, 0);
    check("rst_ready", rdy8, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("release_ready8", rdy8, 1);
    check("release_ready5", rdy5, 1);

    // 8N1, 0xA5, 4 cycles per bit
    send(0, 8'hA5, "0101001011", 4, 1'b0, e[0]);
    wait_idle(0);

    // odd then even parity with two stop bits
    par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1;
    send(0, 8'h03, "011000000111", 4, 1'b0, e[0]);
    wait_idle(0);
    par_typ = 1'b0;
    send(0, 8'h03, "011000000011", 4, 1'b0, e[0]);
    wait_idle(0);

    // six words with DATA_VALID held: consecutive accepts, then frames with no idle gap
    par_en = 1'b0; stop2 = 1'b0; baud_div = 16'd2;
    send(0, 8'h11, "0100010001", 2, 1'b0, e[0]);
    send(0, 8'h22, "0010001001", 2, 1'b1, e[1]);
    send(0, 8'h33, "0110011001", 2, 1'b1, e[2]);
    send(0, 8'h44, "0001000101", 2, 1'b1, e[3]);
    send(0, 8'h55, "0101010101", 2, 1'b1, e[4]);
    send(0, 8'h66, "0011001101", 2, 1'b1, e[5]);
    run = 1;
    for (int i = 1; i < 6; i++) begin
      if (run == i && e[i] == e[0] + i) run++;
    end
    check("accept_run", run, EXP_RUN);
    wait_idle(0);

    // settings changed mid-frame apply only to the next frame
    baud_div = 16'd4; par_en = 1'b0;
    send(0, 8'h5A, "0010110101", 4, 1'b0, e[0]);
    repeat (8) @(negedge CLK);
    baud_div = 16'd2; par_en = 1'b1; par_typ = 1'b0;
    send(0, 8'h0F, "01111000001", 2, 1'b1, e[1]);
    wait_idle(0);

    // reset during DATA with words pending
    mon_off = 1'b1; baud_div = 16'd4; par_en = 1'b0;
    for (int i = 0; i < RST_WORDS; i++) send(0, 8'h80 + 8'(i), "", 4, 1'b0, e[i]);
    repeat (6) @(negedge CLK);
    check("busy_before_rst", busy8, 1);
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_tx", tx8, 1);
    check("midrst_busy", busy8, 0);
    check("midrst_ready", rdy8, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_release_ready", rdy8, 1);
    lows = 0;
    repeat (60) begin
      @(negedge CLK);
      if (tx8 !== 1'b1 || busy8 !== 1'b0) lows++;
    end
    check("no_frame_after_rst", lows, 0);
    mon_off = 1'b0;

    // 5-bit words: BAUD_DIV=0 behaves as 1, then even parity with two stop bits
    baud_div = 16'd0; par_en = 1'b0; stop2 = 1'b0;
    send(1, 8'h1F, "0111111", 1, 1'b0, e[0]);
    wait_idle(1);
    baud_div = 16'd3; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1;
    send(1, 8'h15, "010101111", 3, 1'b0, e[0]);
    wait_idle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
